// File: rtl/cv32e40px_mult_issue.sv
// ---------------------------------------------------------------------------
// cv32e40px_mult_issue
//
// Issue/retire stage in front of cv32e40px_mult. One MUL request from ID is
// registered here and held stable for the whole multiplier operation. The
// multi-cycle MULH sequence is included. The multiplier result is captured
// and offered to writeback with a valid/ready handshake.
//
// A flush cannot abort the MULH sequence inside the multiplier. A flushed
// in-flight op is therefore drained: the stage waits for mult_ready_i and
// then drops the result.
//
// Operator encoding (mul_opcode_e):
//   MAC32=000 MSU32=001 I=010 IR=011 DOT8=100 DOT16=101 H=110
//
// Optional feature macro: MULT_ISSUE_PERF_EN
//   This macro enables the saturating perf counters perf_ops_o and
//   perf_stall_o. When the macro is not defined, both outputs are tied to 0.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   valid_i / ready_o     request handshake from ID
//   operator_i, short_signed_i, short_subword_i, imm_i, op_a/b/c_i
//                         request fields
//   flush_i               kill the op held in the stage
//   mult_*_o              registered request driven to the multiplier
//   mult_ready_i, mult_result_i   multiplier ready_o / result_o
//   mult_ex_ready_o       multiplier ex_ready_i
//   result_valid_o, result_o, result_ready_i   writeback handshake
//   perf_ops_o, perf_stall_o      retired ops / stalled request cycles
//
// The multiplier's rst_n must come from the same reset as rst.
// ---------------------------------------------------------------------------
module cv32e40px_mult_issue #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2:0]           operator_i,
    input  logic [1:0]           short_signed_i,
    input  logic                 short_subword_i,
    input  logic [4:0]           imm_i,
    input  logic [31:0]          op_a_i,
    input  logic [31:0]          op_b_i,
    input  logic [31:0]          op_c_i,
    input  logic                 flush_i,
    output logic                 mult_enable_o,
    output logic [2:0]           mult_operator_o,
    output logic [1:0]           mult_short_signed_o,
    output logic                 mult_short_subword_o,
    output logic [4:0]           mult_imm_o,
    output logic [31:0]          mult_op_a_o,
    output logic [31:0]          mult_op_b_o,
    output logic [31:0]          mult_op_c_o,
    input  logic                 mult_ready_i,
    input  logic [31:0]          mult_result_i,
    output logic                 mult_ex_ready_o,
    output logic                 result_valid_o,
    output logic [31:0]          result_o,
    input  logic                 result_ready_i,
    output logic [CNT_WIDTH-1:0] perf_ops_o,
    output logic [CNT_WIDTH-1:0] perf_stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      r_state;
    logic        r_kill;
    logic        r_mult_en;
    logic        r_res_vld;
    logic [2:0]  r_operator;
    logic [1:0]  r_short_signed;
    logic        r_short_subword;
    logic [4:0]  r_imm;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_op_c;
    logic [31:0] r_result;

    logic w_retire;
    logic w_ready;
    logic w_accept;

    // A flush in RESP takes priority over the writeback handshake.
    // Nothing retires in that cycle, and no new request is accepted.
    assign w_retire = (r_state == S_RESP) & result_ready_i & ~flush_i;
    assign w_ready  = (r_state == S_IDLE) | w_retire;
    assign w_accept = valid_i & w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_kill          <= 1'b0;
            r_mult_en       <= 1'b0;
            r_res_vld       <= 1'b0;
            r_operator      <= '0;
            r_short_signed  <= '0;
            r_short_subword <= 1'b0;
            r_imm           <= '0;
            r_op_a          <= '0;
            r_op_b          <= '0;
            r_op_c          <= '0;
            r_result        <= '0;
        end else begin
            // Accept can only occur in IDLE or on a retire.
            // In both cases the old fields are no longer needed.
            if (w_accept) begin
                r_operator      <= operator_i;
                r_short_signed  <= short_signed_i;
                r_short_subword <= short_subword_i;
                r_imm           <= imm_i;
                r_op_a          <= op_a_i;
                r_op_b          <= op_b_i;
                r_op_c          <= op_c_i;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_EXEC;
                        r_mult_en <= 1'b1;
                    end
                end

                S_EXEC: begin
                    if (mult_ready_i) begin
                        r_mult_en <= 1'b0;
                        r_kill    <= 1'b0;
                        // A flush that arrives on the completing cycle
                        // also discards the result.
                        if (r_kill | flush_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_result  <= mult_result_i;
                            r_res_vld <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end else if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                end

                S_RESP: begin
                    if (flush_i) begin
                        r_res_vld <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (result_ready_i) begin
                        r_res_vld <= 1'b0;
                        if (w_accept) begin
                            r_state   <= S_EXEC;
                            r_mult_en <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_mult_en <= 1'b0;
                    r_res_vld <= 1'b0;
                    r_kill    <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o              = w_ready;
    assign mult_enable_o        = r_mult_en;
    assign mult_operator_o      = r_operator;
    assign mult_short_signed_o  = r_short_signed;
    assign mult_short_subword_o = r_short_subword;
    assign mult_imm_o           = r_imm;
    assign mult_op_a_o          = r_op_a;
    assign mult_op_b_o          = r_op_b;
    assign mult_op_c_o          = r_op_c;
    // The multiplier uses ex_ready_i to leave FINISH.
    // The ready is returned only while this stage is waiting on it.
    assign mult_ex_ready_o      = (r_state == S_EXEC) & mult_ready_i;
    assign result_valid_o       = r_res_vld;
    assign result_o             = r_result;

`ifdef MULT_ISSUE_PERF_EN
    logic [CNT_WIDTH-1:0] r_perf_ops;
    logic [CNT_WIDTH-1:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_retire && (r_perf_ops != {CNT_WIDTH{1'b1}}))
                r_perf_ops <= r_perf_ops + 1'b1;
            if (valid_i && !w_ready && (r_perf_stall != {CNT_WIDTH{1'b1}}))
                r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_ops_o   = r_perf_ops;
    assign perf_stall_o = r_perf_stall;
`else
    assign perf_ops_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40px_mult_issue.sv
// Bench for cv32e40px_mult_issue. A small behavioural multiplier model
// stands in for cv32e40px_mult: non-MULH ops complete at once, and MULH
// steps through IDLE/STEP0/STEP1/STEP2/FINISH. Expected results are pushed
// to a queue at accept and popped on every retire.
module tb_cv32e40px_mult_issue;

    localparam logic [2:0] MUL_MAC32 = 3'b000;
    localparam logic [2:0] MUL_MSU32 = 3'b001;
    localparam logic [2:0] MUL_I     = 3'b010;
    localparam logic [2:0] MUL_H     = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o;
    logic [2:0]  operator_i;
    logic [1:0]  short_signed_i;
    logic        short_subword_i;
    logic [4:0]  imm_i;
    logic [31:0] op_a_i, op_b_i, op_c_i;
    logic        flush_i;
    logic        mult_enable_o;
    logic [2:0]  mult_operator_o;
    logic [1:0]  mult_short_signed_o;
    logic        mult_short_subword_o;
    logic [4:0]  mult_imm_o;
    logic [31:0] mult_op_a_o, mult_op_b_o, mult_op_c_o;
    logic        mult_ready_i;
    logic [31:0] mult_result_i;
    logic        mult_ex_ready_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic        result_ready_i;
    logic [31:0] perf_ops_o, perf_stall_o;

    cv32e40px_mult_issue #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .operator_i(operator_i), .short_signed_i(short_signed_i),
        .short_subword_i(short_subword_i), .imm_i(imm_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i), .flush_i(flush_i),
        .mult_enable_o(mult_enable_o), .mult_operator_o(mult_operator_o),
        .mult_short_signed_o(mult_short_signed_o),
        .mult_short_subword_o(mult_short_subword_o), .mult_imm_o(mult_imm_o),
        .mult_op_a_o(mult_op_a_o), .mult_op_b_o(mult_op_b_o), .mult_op_c_o(mult_op_c_o),
        .mult_ready_i(mult_ready_i), .mult_result_i(mult_result_i),
        .mult_ex_ready_o(mult_ex_ready_o), .result_valid_o(result_valid_o),
        .result_o(result_o), .result_ready_i(result_ready_i),
        .perf_ops_o(perf_ops_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk = ~clk;

    // ---- multiplier model ----
    typedef enum logic [2:0] {M_IDLE, M_S0, M_S1, M_S2, M_FIN} mstate_e;
    mstate_e ms;

    always_ff @(posedge clk) begin
        if (rst) ms <= M_IDLE;
        else if (mult_enable_o && mult_operator_o == MUL_H) begin
            case (ms)
                M_IDLE:  ms <= M_S0;
                M_S0:    ms <= M_S1;
                M_S1:    ms <= M_S2;
                M_S2:    ms <= M_FIN;
                default: if (mult_ex_ready_o) ms <= M_IDLE;
            endcase
        end
    end

    logic signed [32:0] m_ea, m_eb;
    logic signed [65:0] m_ph;
    logic signed [16:0] m_sa, m_sb;
    logic signed [33:0] m_p16;

    always_comb begin
        m_ea  = {mult_short_signed_o[0] & mult_op_a_o[31], mult_op_a_o};
        m_eb  = {mult_short_signed_o[1] & mult_op_b_o[31], mult_op_b_o};
        m_ph  = m_ea * m_eb;
        m_sa  = {mult_short_signed_o[0] & mult_op_a_o[15], mult_op_a_o[15:0]};
        m_sb  = {mult_short_signed_o[1] & mult_op_b_o[15], mult_op_b_o[15:0]};
        m_p16 = (m_sa * m_sb) >>> mult_imm_o;
        mult_ready_i  = 1'b1;
        mult_result_i = mult_op_a_o * mult_op_b_o;
        case (mult_operator_o)
            MUL_MAC32: mult_result_i = mult_op_a_o * mult_op_b_o + mult_op_c_o;
            MUL_MSU32: mult_result_i = mult_op_c_o - mult_op_a_o * mult_op_b_o;
            3'b010, 3'b011: mult_result_i = m_p16[31:0];
            MUL_H: begin
                mult_result_i = m_ph[63:32];
                mult_ready_i  = (ms == M_FIN);
            end
            default: ;
        endcase
    end

    // ---- checking ----
    int n_chk = 0, n_pass = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && result_valid_o && result_ready_i && !flush_i) begin
            if (sb.size() == 0) chk("sb_unexpected_retire", result_o, 32'hxxxx_xxxx);
            else chk("sb_result", result_o, sb.pop_front());
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] ss, input logic [4:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        operator_i = op; short_signed_i = ss; short_subword_i = 1'b0; imm_i = imm;
        op_a_i = a; op_b_i = b; op_c_i = c;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; result_ready_i = 1'b1;
        drive(MUL_MAC32, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Holds valid_i until accepted, then pushes the expected result.
    task automatic issue(input logic [2:0] op, input logic [1:0] ss,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] exp);
        int k;
        drive(op, ss, 5'd0, a, b, c);
        valid_i = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready_o) break;
            nxt();
        end
        if (k == 20) chk("issue_timeout", 32'd0, 32'd1);
        else sb.push_back(exp);
        nxt();
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && ready_o && !result_valid_o) break;
            nxt();
        end
        if (k == 40) chk("drain_timeout", 32'd0, 32'd1);
        nxt();
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        logic [31:0] exp_ops, exp_stall;

        do_reset();
        // reset state
        @(negedge clk);
        chk("rst_vld", result_valid_o, 0);
        chk("rst_en", mult_enable_o, 0);
        chk("rst_res", result_o, 0);
        chk("rst_opa", mult_op_a_o, 0);
        chk("rst_opr", mult_operator_o, 0);
        chk("rst_rdy", ready_o, 1);
        chk("rst_exrdy", mult_ex_ready_o, 0);
        chk("rst_perf_ops", perf_ops_o, 0);
        chk("rst_perf_stall", perf_stall_o, 0);
        nxt();

        // 1: MAC32 3*5+7, 2-cycle latency
        drive(MUL_MAC32, 2'b00, 5'd0, 32'd3, 32'd5, 32'd7); valid_i = 1'b1;
        @(negedge clk); chk("t1_rdy_c0", ready_o, 1); sb.push_back(32'd22);
        nxt(); valid_i = 1'b0;
        @(negedge clk); chk("t1_rdy_c1", ready_o, 0); chk("t1_vld_c1", result_valid_o, 0);
        chk("t1_en_c1", mult_enable_o, 1);
        nxt();
        @(negedge clk); chk("t1_vld_c2", result_valid_o, 1); chk("t1_res_c2", result_o, 32'd22);
        nxt();

        // 2: MULH signed 0x80000000^2, 6-cycle latency
        drive(MUL_H, 2'b11, 5'd0, 32'h8000_0000, 32'h8000_0000, 32'd0); valid_i = 1'b1;
        @(negedge clk); chk("t2_rdy_c0", ready_o, 1); sb.push_back(32'h4000_0000);
        nxt(); valid_i = 1'b0;
        drive(MUL_MAC32, 2'b00, 5'd0, 32'd1, 32'd1, 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t2_rdy_c%0d", c), ready_o, 0);
            chk($sformatf("t2_vld_c%0d", c), result_valid_o, 0);
            if (c == 3) chk("t2_opa_hold", mult_op_a_o, 32'h8000_0000);
            nxt();
        end
        @(negedge clk); chk("t2_vld_c6", result_valid_o, 1); chk("t2_res_c6", result_o, 32'h4000_0000);
        nxt();

        // 3: backpressure; second request waits for the retire cycle
        drive(MUL_MAC32, 2'b00, 5'd0, 32'd3, 32'd5, 32'd7); valid_i = 1'b1; result_ready_i = 1'b0;
        @(negedge clk); sb.push_back(32'd22);
        nxt();
        drive(MUL_I, 2'b00, 5'd0, 32'd2, 32'd3, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("t3_rdy_c%0d", c), ready_o, 0);
            if (c >= 2) chk($sformatf("t3_res_c%0d", c), result_o, 32'd22);
            if (c >= 2) chk($sformatf("t3_vld_c%0d", c), result_valid_o, 1);
            nxt();
        end
        result_ready_i = 1'b1;
        @(negedge clk); chk("t3_rdy_retire", ready_o, 1); sb.push_back(32'd6);
        nxt(); valid_i = 1'b0;
        drain();

        // flush in RESP beats result_ready_i and a same-cycle valid_i
        drive(MUL_MAC32, 2'b00, 5'd0, 32'd1, 32'd1, 32'd1); valid_i = 1'b1; result_ready_i = 1'b0;
        @(negedge clk); nxt(); valid_i = 1'b0;
        @(negedge clk); nxt();
        @(negedge clk); chk("tf_vld_resp", result_valid_o, 1); nxt();
        drive(MUL_I, 2'b00, 5'd0, 32'd2, 32'd3, 32'd0);
        flush_i = 1'b1; result_ready_i = 1'b1; valid_i = 1'b1;
        @(negedge clk); chk("tf_rdy_flush", ready_o, 0);
        nxt(); flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk); chk("tf_vld_after", result_valid_o, 0); chk("tf_rdy_after", ready_o, 1);
        nxt();

        // 4: flush during MULH STEP1; the op is drained and discarded
        drive(MUL_H, 2'b11, 5'd0, 32'h7fff_ffff, 32'h7fff_ffff, 32'd0); valid_i = 1'b1;
        @(negedge clk); nxt(); valid_i = 1'b0;
        @(negedge clk); nxt();            // c1
        @(negedge clk); nxt();            // c2
        flush_i = 1'b1;                   // c3 = STEP1
        @(negedge clk); chk("t4_rdy_c3", ready_o, 0); nxt();
        flush_i = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 5) chk($sformatf("t4_rdy_c%0d", c), ready_o, 0);
            chk($sformatf("t4_vld_c%0d", c), result_valid_o, 0);
            nxt();
        end
        @(negedge clk); chk("t4_rdy_c7", ready_o, 1); chk("t4_vld_c7", result_valid_o, 0);
        nxt();
        issue(MUL_H, 2'b00, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 32'hffff_fffe);
        drain();

        // 5: reset during MULH EXEC
        drive(MUL_H, 2'b11, 5'd0, 32'h1234_5678, 32'h9abc_def0, 32'd0); valid_i = 1'b1;
        @(negedge clk); nxt(); valid_i = 1'b0;
        @(negedge clk); nxt();
        @(negedge clk); nxt();
        rst = 1'b1;
        @(negedge clk); nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_vld", result_valid_o, 0); chk("t5_rdy", ready_o, 1);
        chk("t5_en", mult_enable_o, 0); chk("t5_res", result_o, 0);
        nxt();
        issue(MUL_I, 2'b00, 32'd2, 32'd3, 32'd0, 32'd6);
        drain();

        // random back-to-back MAC32/MSU32
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            if (i[0]) issue(MUL_MSU32, 2'b00, ra, rb, rc, rc - ra * rb);
            else      issue(MUL_MAC32, 2'b00, ra, rb, rc, ra * rb + rc);
        end
        drain();

        // 6: perf counters; MAC32 stalls through the 5 EXEC cycles of MULH
        do_reset();
        drive(MUL_H, 2'b11, 5'd0, 32'h8000_0000, 32'h8000_0000, 32'd0); valid_i = 1'b1;
        @(negedge clk); sb.push_back(32'h4000_0000);
        nxt();
        issue(MUL_MAC32, 2'b00, 32'd3, 32'd5, 32'd7, 32'd22);
        drain();
`ifdef MULT_ISSUE_PERF_EN
        exp_ops = 32'd2; exp_stall = 32'd5;
`else
        exp_ops = 32'd0; exp_stall = 32'd0;
`endif
        chk("t6_perf_ops", perf_ops_o, exp_ops);
        chk("t6_perf_stall", perf_stall_o, exp_stall);
        chk("sb_leftover", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
